// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Latency: 33 cycles from the accepting edge to the ready pulse. Divide by zero takes 1 cycle.
// Backpressure: stall_req holds the pipeline while a request is being accepted or a divide is BUSY.
// Ports:
//   clk, rst (sync, active-low)  - clock and reset
//   start, signed_div, a, b      - request, sampled in IDLE only
//   annul                        - drops a request in IDLE or cancels a BUSY divide
//   result                       - {remainder, quotient}; holds until the next completed divide
//   ready                        - one-cycle pulse when result has just been updated
//   stall_req                    - combinational pipeline-register hold request
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;    // partial remainder
  logic [WIDTH-1:0]   dvd_q,    dvd_d;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0]   dsr_q,    dsr_d;    // divisor magnitude
  logic               neg_q_q,  neg_q_d;  // negate quotient at the end
  logic               neg_r_q,  neg_r_d;  // negate remainder at the end
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  always_comb begin
    // One restoring step. The remainder is always below the divisor, so the
    // shifted value fits in WIDTH+1 bits and the trial sign is its top bit.
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dsr_q};
    q_bit     = ~trial[WIDTH];
    rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {dvd_q[WIDTH-2:0], q_bit};
    rem_fix   = neg_r_q ? (~rem_next + 1'b1) : rem_next;
    quo_fix   = neg_q_q ? (~quo_next + 1'b1) : quo_next;

    // Two's-complement negation of the most negative value returns itself,
    // which is the correct unsigned magnitude.
    mag_a = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = mag_a;
          dsr_d   = mag_b;
          neg_q_d = signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d = signed_div && a[WIDTH-1];
          if (b == '0) begin
            result_d = {a, {WIDTH{1'b1}}};
            state_d  = S_FINISH;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = {rem_fix, quo_fix};
            state_d  = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

  assign result    = result_q;
  assign ready     = (state_q == S_FINISH);
  assign stall_req = ((state_q == S_IDLE) && start && !annul) || (state_q == S_BUSY);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: divide magnitudes, then apply the sign rules.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] mx, my, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    mx = (s && x[31]) ? 32'd0 - x : x;
    my = (s && y[31]) ? 32'd0 - y : y;
    q  = mx / my;
    r  = mx % my;
    if (s && (x[31] ^ y[31])) q = 32'd0 - q;
    if (s && x[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  // Timing model: cycles of divide work left, a finish flag and the visible result.
  int          m_left = 0;
  bit          m_fin  = 1'b0;
  logic [63:0] m_res  = 64'd0;
  logic [63:0] m_pend = 64'd0;
  int          completions = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_left = 0;
      m_fin  = 1'b0;
      m_res  = 64'd0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_left > 0) begin
      if (annul) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_fin = 1'b1;
          m_res = m_pend;
        end
      end
    end else if (start && !annul) begin
      m_pend = ref_div(a, b, signed_div);
      if (b == 32'd0) begin
        m_fin = 1'b1;
        m_res = m_pend;
      end else begin
        m_left = 32;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_int("cyc_ready", int'(ready), int'(m_fin));
      chk_int("cyc_stall", int'(stall_req),
              int'((m_left > 0) || (!m_fin && m_left == 0 && start && !annul)));
      chk64("cyc_result", result, m_res);
      if (ready) completions++;
    end
  end

  task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                         input logic [63:0] exp, input int exp_lat, input int exp_stall,
                         input string name);
    int n;
    int stalls;
    bit got;
    @(posedge clk); #2;
    a = ta; b = tb_v; signed_div = ts; start = 1'b1; annul = 1'b0;
    @(negedge clk);
    stalls = int'(stall_req);
    @(posedge clk); #2;
    start = 1'b0;
    a = $urandom; b = $urandom; signed_div = 1'($urandom);  // must not affect the divide
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ready) got = 1'b1;
      else stalls += int'(stall_req);
    end
    chk_int({name, "_latency"}, got ? n : -1, exp_lat);
    chk64({name, "_result"}, result, exp);
    chk_int({name, "_stall_cycles"}, stalls, exp_stall);
    chk_int({name, "_stall_at_ready"}, int'(stall_req), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;

    // Pin the reference model with hand-computed values.
    chk64("ref_divu_100_7",   ref_div(32'd100, 32'd7, 1'b0),              {32'd2, 32'd14});
    chk64("ref_div_m7_2",     ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk64("ref_div_7_m2",     ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),        {32'd1, 32'hFFFF_FFFD});
    chk64("ref_div_overflow", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
    chk64("ref_div_zero",     ref_div(32'h0000_1234, 32'd0, 1'b0),        {32'h0000_1234, 32'hFFFF_FFFF});
    chk64("ref_divu_big",     ref_div(32'hFFFF_FFF9, 32'd2, 1'b0),        {32'd1, 32'h7FFF_FFFC});

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk64("reset_result", result, 64'd0);
    chk_int("reset_ready", int'(ready), 0);
    chk_int("reset_stall", int'(stall_req), 0);
    @(posedge clk); #2;
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 33, "divu_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33, "div_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, 33, "div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, 33, "div_overflow");
    run_div(32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, 32'hFFFF_FFFF}, 1, 1, "divu_zero");

    // Annul on the 10th BUSY cycle: back to IDLE, no pulse, result held.
    @(posedge clk); #2;
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 annul = 1'b1;
    @(posedge clk); #2;
    annul = 1'b0;
    @(negedge clk);
    chk_int("annul_ready", int'(ready), 0);
    chk_int("annul_stall", int'(stall_req), 0);
    chk64("annul_result_held", result, {32'h0000_1234, 32'hFFFF_FFFF});
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 33, "after_annul_9_3");

    // Start together with annul in IDLE is dropped.
    @(posedge clk); #2;
    a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk_int("start_annul_stall", int'(stall_req), 0);
    @(posedge clk); #2;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk_int("start_annul_idle", int'(stall_req), 0);

    // Reset in the middle of a divide.
    @(posedge clk); #2;
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk64("midreset_result", result, 64'd0);
    chk_int("midreset_ready", int'(ready), 0);
    chk_int("midreset_stall", int'(stall_req), 0);

    // Random traffic; the per-cycle process checks everything against the model.
    completions = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      rst        = ($urandom_range(0, 799) != 0);
      start      = ($urandom_range(0, 2) == 0);
      annul      = ($urandom_range(0, 49) == 0);
      signed_div = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 300);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 20);
        4:       b = 32'd0 - $urandom_range(1, 20);
        default: b = $urandom;
      endcase
    end
    @(posedge clk); #2;
    rst = 1'b1; start = 1'b0; annul = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (completions < 20) begin
      failures++;
      $display("FAIL random_completions actual=%0d required=>=20", completions);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the MIPS execute stage, implementing DIV and DIVU.
- Produces the stall request that drives the enable of the pipeline registers, so the pipeline freezes while a divide is in flight and resumes when the result is ready.
- Output {remainder, quotient} is written to HI/LO by the downstream stage.
- Radix-2 restoring algorithm on operand magnitudes: one quotient bit per cycle, with sign correction at the end.

Parameters:
WIDTH, 32, operand width; the result is 2*WIDTH bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-low; rst=0 at a rising edge resets the block.
start  input  1  request a divide; sampled only in IDLE.
signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
annul  input  1  cancel the in-flight divide (pipeline flush).
a  input  WIDTH  dividend; sampled with start.
b  input  WIDTH  divisor; sampled with start.
result  output  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
ready  output  1  one-cycle pulse: result valid and newly updated.
stall_req  output  1  combinational; pipeline registers hold while it is high.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, result=0, ready=0, iteration counter=0. This applies from any state, including mid-divide. Any partial result is discarded.
- States and transitions:
  - IDLE: on start=1 and annul=0, latch signed_div and the operand magnitudes, and clear the counter.
    - b=0: go to FINISH.
    - otherwise: go to BUSY.
    - start=0 or annul=1: stay in IDLE.
  - BUSY: one restoring step per cycle.
    - Shift the partial remainder left, bringing in the next dividend bit (MSB first).
    - Trial-subtract |b|. If the result is non-negative, keep the difference and set the quotient bit; otherwise restore and clear the bit.
    - Counter increments each cycle. After the step with counter=WIDTH-1, register the sign-corrected result and go to FINISH.
    - annul=1 in BUSY: go to IDLE. result is not updated and ready is not pulsed.
  - FINISH: ready=1 for exactly this one cycle, then unconditionally go to IDLE. start in FINISH is ignored.
- Latency:
  - Start accepted at edge E0: BUSY occupies the cycles after edges E0..E31; ready is high in the cycle after edge E32. That is 33 cycles from the accepting edge.
  - Divide by zero: ready is high in the cycle after E0.
- stall_req = (IDLE & start & ~annul) | BUSY.
  - It is low in FINISH, so the pipeline advances in the same cycle ready is high and captures result.
  - It is low in IDLE when there is no request.
- Signed rules (signed_div=1):
  - Divide the magnitudes |a| and |b| (WIDTH-bit unsigned; |0x80000000| = 0x80000000).
  - Quotient is negated iff a[31]^b[31]. Remainder takes the sign of a.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Unsigned (signed_div=0): operands are used as-is and no correction is applied.
- Divide by zero (either mode): result = {a, 32'hFFFFFFFF}. This value is fixed so that behaviour is deterministic.
- Holding behaviour:
  - result holds its last value until the next completed divide; it is unaffected by annul or by start being ignored.
  - ready is 0 in every state except FINISH.
- Operands are captured at acceptance. Changes on a, b or signed_div during BUSY have no effect.
- annul and start together in IDLE: the request is dropped, stall_req=0, and the block stays in IDLE.

Test Plan:
- Unsigned divide: DIVU a=100, b=7 -> stall_req high for 33 cycles starting with the start cycle; ready pulses one cycle later; result = {0x00000002, 0x0000000E}; stall_req=0 while ready=1.
- Signed divide with negative dividend: DIV a=0xFFFFFFF9 (-7), b=2 -> result = {0xFFFFFFFF, 0xFFFFFFFD}. Also DIV a=7, b=0xFFFFFFFE -> result = {0x00000001, 0xFFFFFFFD}.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> result = {0x00000000, 0x80000000}, no hang.
- Divide by zero: DIVU a=0x00001234, b=0 -> ready in the cycle after the start edge; result = {0x00001234, 0xFFFFFFFF}.
- Annul mid-divide: start 100/7, then assert annul on the 10th BUSY cycle -> IDLE next edge, no ready pulse, result unchanged. A new start of 9/3 on the following cycle then completes with result = {0, 3}.
- Reset mid-divide: drive rst=0 for one edge during BUSY -> result=0, ready=0, stall_req=0. Changing a/b during BUSY in a separate run does not alter the result.
